// File: rtl/apb_cmd_master.sv
// Single-outstanding command-to-APB bridge: accepts one request, runs SETUP/ACCESS
// on APB (with optional wait-state timeout) and returns a held response.
module apb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_write_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_strb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic        apb_psel_o,
    output logic        apb_penable_o,
    output logic        apb_pwrite_o,
    output logic [31:0] apb_paddr_o,
    output logic [31:0] apb_pwdata_o,
    output logic [3:0]  apb_pstrb_o,
    output logic [2:0]  apb_pprot_o,
    input  logic [31:0] apb_prdata_i,
    input  logic        apb_pready_i,
    input  logic        apb_pslverr_i
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic          r_psel;
    logic          r_penable;
    logic          r_pwrite;
    logic [31:0]   r_paddr;
    logic [31:0]   r_pwdata;
    logic [3:0]    r_pstrb;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;
    logic          r_rsp_timeout;
    logic          w_accept;
    logic          w_done;
    logic          w_timeout;
    logic          w_psel_next;
    logic          w_penable_next;
    logic          w_req_ready_next;
    logic          w_rsp_valid_next;

    assign w_accept  = req_valid_i && r_req_ready;
    assign w_done    = (r_state == S_ACCESS) && apb_pready_i;
    assign w_cnt_inc = r_cnt + CW'(1);
    // Fires on the TIMEOUT_CYCLES-th waited ACCESS cycle; pready in that cycle wins.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == S_ACCESS) &&
                       !apb_pready_i && (w_cnt_inc == CNT_LIMIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_SETUP;
            S_SETUP:  w_state_next = S_ACCESS;
            S_ACCESS: if (w_done || w_timeout) w_state_next = S_RESP;
            S_RESP:   if (rsp_ready_i) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Output flops are loaded from the next state so they line up with r_state.
    always_comb begin
        w_psel_next      = (w_state_next == S_SETUP) || (w_state_next == S_ACCESS);
        w_penable_next   = (w_state_next == S_ACCESS);
        w_req_ready_next = (w_state_next == S_IDLE);
        w_rsp_valid_next = (w_state_next == S_RESP);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_cnt         <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_psel      <= w_psel_next;
            r_penable   <= w_penable_next;
            r_req_ready <= w_req_ready_next;
            r_rsp_valid <= w_rsp_valid_next;
            if (w_accept) begin
                r_paddr  <= req_addr_i;
                r_pwrite <= req_write_i;
                r_pwdata <= req_wdata_i;
                r_pstrb  <= req_write_i ? req_strb_i : 4'b0000;
            end
            if (r_state == S_SETUP) begin
                r_cnt <= '0;
            end else if ((r_state == S_ACCESS) && !apb_pready_i && (r_cnt != '1)) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_done) begin
                r_rsp_rdata   <= r_pwrite ? 32'h0 : apb_prdata_i;
                r_rsp_err     <= apb_pslverr_i;
                r_rsp_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_rdata   <= 32'h0;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign req_ready_o   = r_req_ready;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;
    assign apb_psel_o    = r_psel;
    assign apb_penable_o = r_penable;
    assign apb_pwrite_o  = r_pwrite;
    assign apb_paddr_o   = r_paddr;
    assign apb_pwdata_o  = r_pwdata;
    assign apb_pstrb_o   = r_pstrb;
    assign apb_pprot_o   = 3'b000;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: a queue of expected responses is checked by an
// independent response monitor, while the stimulus thread checks APB phase timing.
module tb_apb_cmd_master;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        req_write_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_strb_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        apb_psel_o;
    logic        apb_penable_o;
    logic        apb_pwrite_o;
    logic [31:0] apb_paddr_o;
    logic [31:0] apb_pwdata_o;
    logic [3:0]  apb_pstrb_o;
    logic [2:0]  apb_pprot_o;
    logic [31:0] apb_prdata_i = '0;
    logic        apb_pready_i = 1'b0;
    logic        apb_pslverr_i = 1'b0;

    always #5 clk_i = ~clk_i;

    apb_cmd_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_write_i(req_write_i),
        .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .apb_psel_o(apb_psel_o), .apb_penable_o(apb_penable_o), .apb_pwrite_o(apb_pwrite_o),
        .apb_paddr_o(apb_paddr_o), .apb_pwdata_o(apb_pwdata_o), .apb_pstrb_o(apb_pstrb_o),
        .apb_pprot_o(apb_pprot_o), .apb_prdata_i(apb_prdata_i),
        .apb_pready_i(apb_pready_i), .apb_pslverr_i(apb_pslverr_i)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          rsp_seen = 0;
    int          slv_waits = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0;
    logic [31:0] c_addr = '0;
    logic        c_write = 1'b0;
    logic [31:0] c_wdata = '0;
    logic [3:0]  c_strb = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // Slave: ready on the (slv_waits+1)-th ACCESS cycle; returns data even on writes.
    initial begin : slave
        int acc_n;
        acc_n = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (apb_psel_o && apb_penable_o) begin
                apb_pready_i  = (acc_n == slv_waits);
                apb_pslverr_i = slv_err && (acc_n == slv_waits);
                apb_prdata_i  = (acc_n == slv_waits) ? slv_rdata : 32'h0;
                acc_n++;
            end else begin
                acc_n         = 0;
                apb_pready_i  = 1'b0;
                apb_pslverr_i = 1'b0;
                apb_prdata_i  = 32'h0;
            end
        end
    end

    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk_i);
            if (rsp_valid_o && rsp_ready_i) begin
                rsp_seen++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got response rdata 0x%0h, required none", rsp_rdata_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
                    chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
                    chk("rsp_timeout", 64'(rsp_timeout_o), 64'(e.to));
                    $display("rsp %0d: rdata=0x%08h err=%0d timeout=%0d", rsp_seen, rsp_rdata_o, rsp_err_o, rsp_timeout_o);
                end
            end
        end
    end

    task automatic set_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input bit push, input logic [31:0] e_rd,
                           input logic e_err, input logic e_to);
        rsp_t e;
        req_addr_i = a; req_write_i = w; req_wdata_i = d; req_strb_i = s;
        req_valid_i = 1'b1;
        c_addr = a; c_write = w; c_wdata = d; c_strb = s;
        if (push) begin
            e.rdata = e_rd; e.err = e_err; e.to = e_to;
            exp_q.push_back(e);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input bit push, input logic [31:0] e_rd,
                         input logic e_err, input logic e_to);
        bit got;
        tick();
        set_cmd(a, w, d, s, push, e_rd, e_err, e_to);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_i);
            if (req_ready_o) got = 1'b1;
            else tick();
        end
        chk("accept", 64'(got), 64'd1);
    endtask

    // From the cycle after acceptance: SETUP, ACCESS run, then first RESP cycle.
    task automatic follow(input int exp_acc, input string name);
        int n;
        bit done;
        bit hold_ok;
        logic [3:0] e_strb;
        n = 0;
        done = 1'b0;
        e_strb = c_write ? c_strb : 4'b0000;
        tick();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk({name, "_setup_ctl"}, 64'({apb_psel_o, apb_penable_o, apb_pwrite_o}), 64'({2'b10, c_write}));
        chk({name, "_setup_addr"}, 64'(apb_paddr_o), 64'(c_addr));
        chk({name, "_setup_data"}, 64'({apb_pstrb_o, apb_pprot_o, apb_pwdata_o}), 64'({e_strb, 3'b000, c_wdata}));
        hold_ok = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            @(negedge clk_i);
            if (apb_psel_o && apb_penable_o) begin
                n++;
                if (apb_paddr_o !== c_addr || apb_pwdata_o !== c_wdata ||
                    apb_pwrite_o !== c_write || apb_pstrb_o !== e_strb) hold_ok = 1'b0;
            end else begin
                done = 1'b1;
            end
        end
        chk({name, "_access_hold"}, 64'(hold_ok), 64'd1);
        chk({name, "_access_cycles"}, 64'(n), 64'(exp_acc));
        chk({name, "_resp_ctl"}, 64'({rsp_valid_o, apb_psel_o, apb_penable_o}), 64'(3'b100));
        $display("txn %s: addr=0x%08h write=%0d access_cycles=%0d", name, c_addr, c_write, n);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        @(negedge clk_i);
        @(negedge clk_i);
        chk("reset_ctl", 64'({req_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, apb_psel_o,
                              apb_penable_o, apb_pwrite_o, apb_pstrb_o, apb_pprot_o}), 64'd0);
        chk("reset_data", {rsp_rdata_o, apb_paddr_o}, 64'd0);
        chk("reset_pwdata", 64'(apb_pwdata_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("ready_before_edge", 64'(req_ready_o), 64'd0);
        @(negedge clk_i);
        chk("ready_after_edge", 64'(req_ready_o), 64'd1);

        slv_waits = 0; slv_rdata = 32'h5555_AAAA; slv_err = 1'b0;
        issue(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
        follow(1, "wr_zero_wait");

        slv_waits = 3; slv_rdata = 32'h1234_5678;
        issue(32'h0000_0004, 1'b0, 32'h1111_2222, 4'hF, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        follow(4, "rd_3_waits");

        slv_waits = 1; slv_rdata = 32'h7777_0000; slv_err = 1'b1;
        issue(32'h0000_0100, 1'b1, 32'hA5A5_5A5A, 4'h3, 1'b1, 32'h0, 1'b1, 1'b0);
        follow(2, "wr_slverr");

        slv_waits = 100; slv_err = 1'b0; slv_rdata = 32'h9999_9999;
        issue(32'h0000_0200, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1, 1'b1);
        follow(4, "rd_timeout");

        slv_waits = 3; slv_rdata = 32'h0BAD_CAFE;
        issue(32'h0000_0204, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0BAD_CAFE, 1'b0, 1'b0);
        follow(4, "rd_ready_at_limit");

        // Backpressure: response must hold while a new command waits.
        tick();
        rsp_ready_i = 1'b0;
        slv_waits = 0; slv_rdata = 32'hCAFE_F00D;
        issue(32'h0000_0008, 1'b0, 32'h0, 4'hF, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
        follow(1, "rd_hold");
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                slv_rdata = 32'h0;
                set_cmd(32'h0000_0020, 1'b1, 32'h0BAD_F00D, 4'h5, 1'b1, 32'h0, 1'b0, 1'b0);
            end
            @(negedge clk_i);
            chk("hold_req_ready", 64'(req_ready_o), 64'd0);
            chk("hold_rsp", 64'({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o}), 64'({3'b100, 32'hCAFE_F00D}));
        end
        tick();
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        chk("handshake_req_ready", 64'(req_ready_o), 64'd0);
        tick();
        @(negedge clk_i);
        chk("post_handshake_ready", 64'(req_ready_o), 64'd1);
        follow(1, "wr_after_hold");

        // Reset during ACCESS: transfer discarded, no response.
        slv_waits = 100;
        issue(32'h0000_0040, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rst_pre_setup", 64'({apb_psel_o, apb_penable_o}), 64'(2'b10));
        tick();
        @(negedge clk_i);
        chk("rst_pre_access", 64'({apb_psel_o, apb_penable_o}), 64'(2'b11));
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_async_drop", 64'({apb_psel_o, apb_penable_o, rsp_valid_o, req_ready_o}), 64'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            chk("rst_no_rsp", 64'(rsp_valid_o), 64'd0);
        end
        slv_waits = 0; slv_rdata = 32'h0;
        issue(32'h0000_0080, 1'b1, 32'h0102_0304, 4'h8, 1'b1, 32'h0, 1'b0, 1'b0);
        follow(1, "wr_after_reset");

        tick();
        tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("rsp_count", 64'(rsp_seen), 64'd8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
